// File: rtl/tpu_pkg.sv
// Shared definitions for the TPU control sequencer: state encoding and the
// default systolic drain length.
package tpu_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    WAIT_W = 3'd1,
    POP_W  = 3'd2,
    LOAD_W = 3'd3,
    STREAM = 3'd4,
    DRAIN  = 3'd5,
    DONE   = 3'd6
  } state_e;

  // The last result leaves the array rows+cols-1 cycles after the last vector enters.
  function automatic int drain_default(input int rows, input int cols);
    return rows + cols - 1;
  endfunction

endpackage

// File: rtl/tpu_addr_gen.sv
// Input-vector address generator: latches base and count on load, steps the
// address with wrap at 2^AW, and flags the final vector of the stream.
module tpu_addr_gen #(
  parameter int AW = 10
) (
  input  logic          clk,
  input  logic          rstn,
  input  logic          load_i,
  input  logic [AW-1:0] base_i,
  input  logic [AW:0]   count_i,
  input  logic          step_i,
  output logic [AW-1:0] addr_o,
  output logic          last_o,
  output logic          zero_o
);

  logic [AW-1:0] addr_q, addr_d;
  logic [AW:0]   cnt_q, cnt_d;
  logic [AW:0]   vc_q, vc_d;

  // Load on accept, otherwise advance one vector per step; address wraps naturally.
  always_comb begin
    addr_d = addr_q;
    cnt_d  = cnt_q;
    vc_d   = vc_q;
    if (load_i) begin
      addr_d = base_i;
      cnt_d  = '0;
      vc_d   = count_i;
    end else if (step_i) begin
      addr_d = addr_q + AW'(1);
      cnt_d  = cnt_q + (AW+1)'(1);
    end
  end

  // Address and counter state.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      addr_q <= '0;
      cnt_q  <= '0;
      vc_q   <= '0;
    end else begin
      addr_q <= addr_d;
      cnt_q  <= cnt_d;
      vc_q   <= vc_d;
    end
  end

  assign addr_o = addr_q;
  assign last_o = (cnt_q + (AW+1)'(1)) == vc_q;
  assign zero_o = (vc_q == '0);

endmodule

// File: rtl/tpu_seq_ctrl.sv
// Control sequencer for the TOP_tpu datapath: per start, pop one weight tile,
// load it into the PE array, stream input vectors from SRAM, wait out the
// systolic drain and pulse end_. Every output comes straight from a flop.
// Optional feature: define SEQ_CYCLE_COUNT_EN to add the cycle_count output.
module tpu_seq_ctrl import tpu_pkg::*; #(
  parameter int ADDRESSSIZE  = 10,
  parameter int MATRIX_SIZE  = 8,
  parameter int NUM_PE_ROWS  = 8,
  parameter int DRAIN_CYCLES = drain_default(NUM_PE_ROWS, MATRIX_SIZE)
) (
  input  logic                   clk,
  input  logic                   rstn,
  input  logic                   start,
  input  logic [ADDRESSSIZE-1:0] base_addr,
  input  logic [ADDRESSSIZE:0]   vec_count,
  input  logic                   fifo_empty,
  output logic                   fifo_read_enable,
  output logic                   we_rl,
  output logic [ADDRESSSIZE-1:0] sram_address,
  output logic                   valid_address,
  output logic                   busy,
  output logic                   end_
`ifdef SEQ_CYCLE_COUNT_EN
  ,
  output logic [15:0]            cycle_count
`endif
);

  localparam int DW = (DRAIN_CYCLES < 2) ? 1 : $clog2(DRAIN_CYCLES + 1);

  state_e        state_q, state_d;
  logic [DW-1:0] drain_q, drain_d;
  logic          fifo_read_enable_q, fifo_read_enable_d;
  logic          we_rl_q, we_rl_d;
  logic          valid_address_q, valid_address_d;
  logic          busy_q, busy_d;
  logic          end_q, end_d;

  logic          accept;
  logic          step;
  logic          last_vec;
  logic          zero_vec;

  assign accept = (state_q == IDLE) && start;
  // Hold the address on the final vector so it stays put through DRAIN.
  assign step   = (state_q == STREAM) && !last_vec;

  tpu_addr_gen #(
    .AW (ADDRESSSIZE)
  ) u_addr_gen (
    .clk    (clk),
    .rstn   (rstn),
    .load_i (accept),
    .base_i (base_addr),
    .count_i(vec_count),
    .step_i (step),
    .addr_o (sram_address),
    .last_o (last_vec),
    .zero_o (zero_vec)
  );

  // Next-state logic; output flops are decoded from the next state so they line up with it.
  always_comb begin
    state_d = state_q;
    drain_d = drain_q;
    case (state_q)
      IDLE:   if (start) state_d = WAIT_W;
      WAIT_W: if (!fifo_empty) state_d = POP_W;
      POP_W:  state_d = LOAD_W;
      LOAD_W: begin
        state_d = zero_vec ? DRAIN : STREAM;
        drain_d = '0;
      end
      STREAM: begin
        if (last_vec) state_d = DRAIN;
        drain_d = '0;
      end
      DRAIN: begin
        if (drain_q == DW'(DRAIN_CYCLES - 1)) state_d = DONE;
        else drain_d = drain_q + DW'(1);
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
    fifo_read_enable_d = (state_d == POP_W);
    we_rl_d            = (state_d == LOAD_W);
    valid_address_d    = (state_d == STREAM);
    busy_d             = (state_d != IDLE);
    end_d              = (state_d == DONE);
  end

  // Sequencer state and registered control outputs.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q            <= IDLE;
      drain_q            <= '0;
      fifo_read_enable_q <= 1'b0;
      we_rl_q            <= 1'b0;
      valid_address_q    <= 1'b0;
      busy_q             <= 1'b0;
      end_q              <= 1'b0;
    end else begin
      state_q            <= state_d;
      drain_q            <= drain_d;
      fifo_read_enable_q <= fifo_read_enable_d;
      we_rl_q            <= we_rl_d;
      valid_address_q    <= valid_address_d;
      busy_q             <= busy_d;
      end_q              <= end_d;
    end
  end

  assign fifo_read_enable = fifo_read_enable_q;
  assign we_rl            = we_rl_q;
  assign valid_address    = valid_address_q;
  assign busy             = busy_q;
  assign end_             = end_q;

`ifdef SEQ_CYCLE_COUNT_EN
  logic [15:0] cycle_count_q, cycle_count_d;

  // The accept cycle counts as the first; then one per busy cycle, saturating.
  always_comb begin
    cycle_count_d = cycle_count_q;
    if (accept) cycle_count_d = 16'd1;
    else if (busy_q && (cycle_count_q != 16'hFFFF)) cycle_count_d = cycle_count_q + 16'd1;
  end

  // Cycle counter register.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) cycle_count_q <= '0;
    else       cycle_count_q <= cycle_count_d;
  end

  assign cycle_count = cycle_count_q;
`endif

endmodule

// File: tb/tb_tpu_seq_ctrl.sv
// Scoreboard bench for tpu_seq_ctrl: each transaction's expected control
// events (pop, load, addresses, end) are computed from the cycle timeline and
// queued; a monitor pops and compares whenever the DUT drives a control pin.
module tb_tpu_seq_ctrl;

  localparam int AW = 10;
  localparam int D  = 15;
  localparam int K_POP = 0, K_WE = 1, K_VEC = 2, K_END = 3;

  logic          clk = 1'b0;
  logic          rstn;
  logic          start = 1'b0;
  logic [AW-1:0] base_addr = '0;
  logic [AW:0]   vec_count = '0;
  logic          fifo_empty = 1'b0;
  logic          fifo_read_enable, we_rl, valid_address, busy, end_;
  logic [AW-1:0] sram_address;
`ifdef SEQ_CYCLE_COUNT_EN
  logic [15:0]   cycle_count;
`endif

  typedef struct { int kind; int cyc; int addr; } ev_t;
  ev_t q[$];

  int cyc = 0;
  int n_chk = 0;
  int n_fail = 0;
  int busy_lo = 1, busy_hi = 0;

  tpu_seq_ctrl dut (
    .clk             (clk),
    .rstn            (rstn),
    .start           (start),
    .base_addr       (base_addr),
    .vec_count       (vec_count),
    .fifo_empty      (fifo_empty),
    .fifo_read_enable(fifo_read_enable),
    .we_rl           (we_rl),
    .sram_address    (sram_address),
    .valid_address   (valid_address),
    .busy            (busy),
    .end_            (end_)
`ifdef SEQ_CYCLE_COUNT_EN
    ,
    .cycle_count     (cycle_count)
`endif
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input longint act, input longint exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s at cycle %0d: got %0h, expected %0h", nm, cyc, act, exp);
    end
  endtask

  // Monitor: busy window, one control pin at a time, scoreboard pop on activity.
  always @(negedge clk) begin
    int na, k;
    ev_t e;
    if (rstn === 1'b1) begin
      na = int'(fifo_read_enable) + int'(we_rl) + int'(valid_address) + int'(end_);
      k  = fifo_read_enable ? K_POP : we_rl ? K_WE : valid_address ? K_VEC : end_ ? K_END : -1;
      chk("busy", busy, (cyc >= busy_lo && cyc <= busy_hi));
      if (na > 1) chk("ctrl_onehot", na, 1);
      if (na != 0) begin
        if (q.size() == 0) chk("unexpected_ctrl", k, -1);
        else begin
          e = q.pop_front();
          chk("ev_kind", k, e.kind);
          chk("ev_cycle", cyc, e.cyc);
          if (e.kind == K_VEC) chk("sram_address", sram_address, e.addr);
        end
      end
    end
  end

  // Expected timeline from the accept edge (observed cycle a = WAIT_W).
  task automatic push_model(input int a, input int base, input int vec, input int w, output int e);
    int pop;
    pop = a + 1 + w;
    q.push_back('{K_POP, pop, 0});
    q.push_back('{K_WE, pop + 1, 0});
    for (int k = 0; k < vec; k++) q.push_back('{K_VEC, pop + 2 + k, (base + k) % 1024});
    e = pop + vec + D + 2;
    q.push_back('{K_END, e, 0});
    busy_lo = a;
    busy_hi = e;
  endtask

  // One full transaction: w empty-FIFO cycles, optional stray starts in STREAM and DONE.
  task automatic run_txn(input int base, input int vec, input int w, input bit stray);
    int a, e;
    a = cyc + 1;
    push_model(a, base, vec, w, e);
    base_addr  = AW'(base);
    vec_count  = (AW+1)'(vec);
    fifo_empty = (w > 0);
    start      = 1'b1;
    @(negedge clk);
    start = 1'b0;
    while (cyc <= e) begin
      if (cyc == a) begin
        base_addr = AW'($urandom);
        vec_count = (AW+1)'($urandom);
      end
      if (w > 0 && cyc == a + w) fifo_empty = 1'b0;
      else if (cyc > a + w) fifo_empty = 1'($urandom_range(0, 1));
      if (stray && cyc == a + w + 4) start = 1'b1;
      if (stray && cyc == a + w + 5) start = 1'b0;
      if (stray && cyc == e) start = 1'b1;
      if (cyc == e) chk("addr_hold", sram_address, (base + ((vec > 0) ? vec - 1 : 0)) % 1024);
      @(negedge clk);
    end
    start      = 1'b0;
    fifo_empty = 1'b0;
    chk("queue_empty", q.size(), 0);
`ifdef SEQ_CYCLE_COUNT_EN
    chk("cycle_count", cycle_count, vec + D + 5 + w);
`endif
  endtask

  // Abort a stream with an asynchronous reset.
  task automatic reset_mid_stream();
    int a, e;
    a = cyc + 1;
    push_model(a, 100, 20, 0, e);
    base_addr = AW'(100);
    vec_count = (AW+1)'(20);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (6) @(negedge clk);
    #2 rstn = 1'b0;
    #1;
    chk("rst_fifo_read_enable", fifo_read_enable, 0);
    chk("rst_we_rl", we_rl, 0);
    chk("rst_valid_address", valid_address, 0);
    chk("rst_sram_address", sram_address, 0);
    chk("rst_busy", busy, 0);
    chk("rst_end", end_, 0);
    q.delete();
    busy_lo = 1;
    busy_hi = 0;
    repeat (3) @(negedge clk);
    chk("rst_hold_end", end_, 0);
`ifdef SEQ_CYCLE_COUNT_EN
    chk("rst_cycle_count", cycle_count, 0);
`endif
    rstn = 1'b1;
    @(negedge clk);
  endtask

  initial begin
    int b, v, w;
    rstn = 1'b1;
    #1 rstn = 1'b0;
    #1;
    chk("init_fifo_read_enable", fifo_read_enable, 0);
    chk("init_we_rl", we_rl, 0);
    chk("init_valid_address", valid_address, 0);
    chk("init_sram_address", sram_address, 0);
    chk("init_busy", busy, 0);
    chk("init_end", end_, 0);
    repeat (3) @(negedge clk);
    rstn = 1'b1;
    @(negedge clk);

    run_txn(0, 16, 0, 1'b0);       // basic
    run_txn(5, 6, 5, 1'b0);        // empty FIFO for 5 cycles
    run_txn(10'h3FE, 4, 0, 1'b0);  // address wrap
    run_txn(7, 0, 0, 1'b0);        // zero vectors
    run_txn(20, 8, 1, 1'b1);       // stray starts in STREAM and DONE
    run_txn(300, 3, 0, 1'b0);      // accepted in the first IDLE after DONE
    reset_mid_stream();
    run_txn(0, 16, 0, 1'b0);       // fresh run after reset

    for (int i = 0; i < 25; i++) begin
      repeat ($urandom_range(0, 3)) @(negedge clk);
      b = $urandom_range(0, 1023);
      v = (i % 5 == 0) ? $urandom_range(0, 2) : $urandom_range(0, 40);
      w = $urandom_range(0, 4);
      run_txn(b, v, w, (v >= 3) && ($urandom_range(0, 1) == 1));
    end

    repeat (5) @(negedge clk);
    chk("final_queue_empty", q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
